tone_sweep_ctrl: RTL and testbench

//  Sequencer driving phase_step of the sine generator for frequency-sweep test signals.

---
 rtl/tone_sweep_pkg.sv | 20 ++
 rtl/dwell_counter.sv | 41 ++++
 rtl/tone_sweep_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_tone_sweep_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tone_sweep_pkg.sv
// Shared types and defaults for the tone sweep sequencer.
package tone_sweep_pkg;

  localparam int unsigned STEP_W_DEFAULT  = 32;
  localparam int unsigned DWELL_W_DEFAULT = 24;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } sweep_state_t;

  typedef enum logic [1:0] {
    MODE_ONESHOT  = 2'd0,
    MODE_LOOP     = 2'd1,
    MODE_PINGPONG = 2'd2,
    MODE_RSVD     = 2'd3
  } sweep_mode_t;

endpackage

// File: rtl/dwell_counter.sv
// Counts sample ticks per step; term pulses on the tick that completes the dwell.
module dwell_counter
  import tone_sweep_pkg::*;
#(
  parameter int unsigned DWELL_W = DWELL_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               clear,
  input  logic               enable,
  input  logic               tick,
  input  logic [DWELL_W-1:0] dwell,
  output logic               term
);

  logic [DWELL_W-1:0] cnt_q;
  logic [DWELL_W-1:0] cnt_d;
  logic [DWELL_W-1:0] last;

  // A dwell of zero behaves as a dwell of one.
  always_comb begin
    last  = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
    term  = enable && tick && !clear && !load && (cnt_q == last);
    cnt_d = cnt_q;
    if (clear || load || !enable) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = term ? '0 : cnt_q + DWELL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tone_sweep_ctrl.sv
// Frequency-sweep sequencer driving sine_wave.phase_step.
module tone_sweep_ctrl
  import tone_sweep_pkg::*;
#(
  parameter int unsigned STEP_W  = STEP_W_DEFAULT,
  parameter int unsigned DWELL_W = DWELL_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sample_tick,
  input  logic               start,
  input  logic               abort,
  input  logic [1:0]         cfg_mode,
  input  logic [STEP_W-1:0]  cfg_start_step,
  input  logic [STEP_W-1:0]  cfg_stop_step,
  input  logic [STEP_W-1:0]  cfg_inc,
  input  logic [DWELL_W-1:0] cfg_dwell,
  output logic [STEP_W-1:0]  phase_step,
  output logic               busy,
  output logic               step_upd,
  output logic               done,
  output logic               cfg_err
);

  sweep_state_t       state_q, state_d;
  logic [STEP_W-1:0]  phase_step_q, phase_step_d;
  logic               step_upd_q, step_upd_d;
  logic               cfg_err_q, cfg_err_d;
  logic               dir_down_q, dir_down_d;

  sweep_mode_t        mode_q, mode_d;
  logic [STEP_W-1:0]  start_q, start_d;
  logic [STEP_W-1:0]  stop_q, stop_d;
  logic [STEP_W-1:0]  inc_q, inc_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;

  logic               cfg_ok;
  logic               accept;
  logic               term;
  logic [STEP_W:0]    up_sum;
  logic [STEP_W:0]    dn_diff;
  logic [STEP_W-1:0]  up_val;
  logic [STEP_W-1:0]  dn_val;

  dwell_counter #(
    .DWELL_W(DWELL_W)
  ) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .clear (abort),
    .enable(state_q == RUN),
    .tick  (sample_tick),
    .dwell (dwell_q),
    .term  (term)
  );

  // Extra top bit carries overflow/borrow so the result clamps instead of wrapping.
  always_comb begin
    up_sum  = {1'b0, phase_step_q} + {1'b0, inc_q};
    dn_diff = {1'b0, phase_step_q} - {1'b0, inc_q};
    up_val  = (up_sum[STEP_W] || (up_sum[STEP_W-1:0] > stop_q)) ? stop_q : up_sum[STEP_W-1:0];
    dn_val  = (dn_diff[STEP_W] || (dn_diff[STEP_W-1:0] < start_q)) ? start_q : dn_diff[STEP_W-1:0];
  end

  assign cfg_ok = (cfg_start_step <= cfg_stop_step) && (sweep_mode_t'(cfg_mode) != MODE_RSVD);
  assign accept = (state_q == IDLE) && start && !abort && cfg_ok;

  always_comb begin
    state_d      = state_q;
    phase_step_d = phase_step_q;
    step_upd_d   = 1'b0;
    cfg_err_d    = 1'b0;
    dir_down_d   = dir_down_q;
    mode_d       = mode_q;
    start_d      = start_q;
    stop_d       = stop_q;
    inc_d        = inc_q;
    dwell_d      = dwell_q;

    if (abort) begin
      state_d      = IDLE;
      phase_step_d = '0;
      dir_down_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              mode_d       = sweep_mode_t'(cfg_mode);
              start_d      = cfg_start_step;
              stop_d       = cfg_stop_step;
              inc_d        = cfg_inc;
              dwell_d      = cfg_dwell;
              state_d      = RUN;
              phase_step_d = cfg_start_step;
              step_upd_d   = 1'b1;
              dir_down_d   = 1'b0;
            end else begin
              cfg_err_d = 1'b1;
            end
          end
        end

        RUN: begin
          // A zero increment is a fixed tone: nothing moves until abort.
          if (term && (inc_q != '0)) begin
            if (!dir_down_q) begin
              if (phase_step_q != stop_q) begin
                phase_step_d = up_val;
                step_upd_d   = 1'b1;
              end else begin
                unique case (mode_q)
                  MODE_ONESHOT: begin
                    state_d      = FINISH;
                    phase_step_d = '0;
                  end
                  MODE_LOOP: begin
                    phase_step_d = start_q;
                    step_upd_d   = 1'b1;
                  end
                  default: begin
                    dir_down_d   = 1'b1;
                    phase_step_d = dn_val;
                    step_upd_d   = (dn_val != phase_step_q);
                  end
                endcase
              end
            end else begin
              if (phase_step_q != start_q) begin
                phase_step_d = dn_val;
                step_upd_d   = 1'b1;
              end else begin
                dir_down_d   = 1'b0;
                phase_step_d = up_val;
                step_upd_d   = (up_val != phase_step_q);
              end
            end
          end
        end

        FINISH: begin
          state_d = IDLE;
        end

        default: begin
          state_d      = IDLE;
          phase_step_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      phase_step_q <= '0;
      step_upd_q   <= 1'b0;
      cfg_err_q    <= 1'b0;
      dir_down_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_step_q <= phase_step_d;
      step_upd_q   <= step_upd_d;
      cfg_err_q    <= cfg_err_d;
      dir_down_q   <= dir_down_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= MODE_ONESHOT;
      start_q <= '0;
      stop_q  <= '0;
      inc_q   <= '0;
      dwell_q <= '0;
    end else begin
      mode_q  <= mode_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      inc_q   <= inc_d;
      dwell_q <= dwell_d;
    end
  end

  assign phase_step = phase_step_q;
  assign busy       = (state_q == RUN);
  assign step_upd   = step_upd_q;
  assign done       = (state_q == FINISH);
  assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_tone_sweep_ctrl.sv
// Scoreboard bench for tone_sweep_ctrl.
module tb_tone_sweep_ctrl;
  import tone_sweep_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_tick = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [1:0]  cfg_mode = 2'd0;
  logic [31:0] cfg_start_step = '0;
  logic [31:0] cfg_stop_step = '0;
  logic [31:0] cfg_inc = '0;
  logic [23:0] cfg_dwell = '0;
  logic [31:0] phase_step;
  logic        busy;
  logic        step_upd;
  logic        done;
  logic        cfg_err;

  int errors = 0;
  int checks = 0;
  int upd_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  logic [31:0] exp_q[$];

  tone_sweep_ctrl #(
    .STEP_W (32),
    .DWELL_W(24)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sample_tick   (sample_tick),
    .start         (start),
    .abort         (abort),
    .cfg_mode      (cfg_mode),
    .cfg_start_step(cfg_start_step),
    .cfg_stop_step (cfg_stop_step),
    .cfg_inc       (cfg_inc),
    .cfg_dwell     (cfg_dwell),
    .phase_step    (phase_step),
    .busy          (busy),
    .step_upd      (step_upd),
    .done          (done),
    .cfg_err       (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    sample_tick = 1'b1;
    cyc();
    sample_tick = 1'b0;
    cyc();
  endtask

  task automatic start_sweep(input logic [1:0] m, input logic [31:0] s, input logic [31:0] e,
                             input logic [31:0] i, input logic [23:0] d);
    cfg_mode       = m;
    cfg_start_step = s;
    cfg_stop_step  = e;
    cfg_inc        = i;
    cfg_dwell      = d;
    start          = 1'b1;
    cyc();
    start          = 1'b0;
  endtask

  task automatic sb_monitor();
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
      if (cfg_err === 1'b1) err_cnt++;
      if (step_upd === 1'b1) begin
        upd_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_step_upd: phase_step=%0h updated, no update expected", phase_step);
        end else begin
          e = exp_q.pop_front();
          if (phase_step !== e) begin
            errors++;
            $display("FAIL sb_phase_step: got %0h expected %0h", phase_step, e);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (phase_step !== 32'h0) begin errors++; $display("FAIL reset_phase: got %0h expected 0", phase_step); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (step_upd !== 1'b0) begin errors++; $display("FAIL reset_upd: got %b expected 0", step_upd); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", cfg_err); end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_oneshot();
    int          done0;
    logic [31:0] e;
    done0 = done_cnt;
    exp_q.push_back(32'd100);
    sample_tick = 1'b1;
    start_sweep(MODE_ONESHOT, 100, 400, 100, 2);
    sample_tick = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL oneshot_busy: got %b expected 1", busy); end
    checks++; if (phase_step !== 32'd100) begin errors++; $display("FAIL oneshot_load: got %0d expected 100", phase_step); end
    for (int k = 1; k <= 8; k++) begin
      if ((k % 2 == 0) && (k < 8)) exp_q.push_back(32'(100 * (k / 2 + 1)));
      pulse_tick();
      e = (k == 8) ? 32'd0 : 32'(100 * (k / 2 + 1));
      checks++; if (phase_step !== e) begin errors++; $display("FAIL oneshot_tick%0d: got %0d expected %0d", k, phase_step, e); end
      checks++; if (busy !== (k < 8)) begin errors++; $display("FAIL oneshot_busy%0d: got %b expected %b", k, busy, k < 8); end
    end
    checks++; if (done_cnt - done0 != 1) begin errors++; $display("FAIL oneshot_done: got %0d pulses expected 1", done_cnt - done0); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL oneshot_pending: got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_clamp();
    int          done0;
    int          upd0;
    logic [31:0] vals [3];
    vals  = '{32'd200, 32'd300, 32'd350};
    done0 = done_cnt;
    upd0  = upd_cnt;
    exp_q.push_back(32'd100);
    start_sweep(MODE_ONESHOT, 100, 350, 100, 1);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(vals[i]);
      pulse_tick();
      checks++; if (phase_step !== vals[i]) begin errors++; $display("FAIL clamp_step%0d: got %0d expected %0d", i, phase_step, vals[i]); end
    end
    sample_tick = 1'b1;
    cyc();
    sample_tick = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL clamp_done_cycle: got %b expected 1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clamp_finish_busy: got %b expected 0", busy); end
    checks++; if (phase_step !== 32'd0) begin errors++; $display("FAIL clamp_finish_phase: got %0d expected 0", phase_step); end
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL finish_start_ignored: busy got %b expected 0", busy); end
    checks++; if (upd_cnt - upd0 != 4) begin errors++; $display("FAIL clamp_upd_count: got %0d expected 4", upd_cnt - upd0); end
    checks++; if (done_cnt - done0 != 1) begin errors++; $display("FAIL clamp_done: got %0d pulses expected 1", done_cnt - done0); end
  endtask

  task automatic test_loop();
    int          done0;
    logic [31:0] vals [4];
    vals  = '{32'd20, 32'd30, 32'd10, 32'd20};
    done0 = done_cnt;
    exp_q.push_back(32'd10);
    start_sweep(MODE_LOOP, 10, 30, 10, 1);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(vals[i]);
      pulse_tick();
      checks++; if (phase_step !== vals[i]) begin errors++; $display("FAIL loop_step%0d: got %0d expected %0d", i, phase_step, vals[i]); end
    end
    abort       = 1'b1;
    sample_tick = 1'b1;
    cyc();
    abort       = 1'b0;
    sample_tick = 1'b0;
    checks++; if (phase_step !== 32'd0) begin errors++; $display("FAIL loop_abort_phase: got %0d expected 0", phase_step); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL loop_abort_busy: got %b expected 0", busy); end
    cyc();
    cyc();
    checks++; if (done_cnt != done0) begin errors++; $display("FAIL loop_no_done: got %0d pulses expected 0", done_cnt - done0); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL loop_pending: got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_pingpong();
    logic [31:0] vals [8];
    vals = '{32'd8, 32'd16, 32'd20, 32'd12, 32'd4, 32'd0, 32'd8, 32'd16};
    exp_q.push_back(32'd0);
    start_sweep(MODE_PINGPONG, 0, 20, 8, 1);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(vals[i]);
      pulse_tick();
      checks++; if (phase_step !== vals[i]) begin errors++; $display("FAIL pp_step%0d: got %0d expected %0d", i, phase_step, vals[i]); end
    end
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    checks++; if (busy !== 1'b0 || phase_step !== 32'd0) begin errors++; $display("FAIL pp_abort: got busy=%b phase=%0d expected busy=0 phase=0", busy, phase_step); end
  endtask

  task automatic test_wrap();
    int          done0;
    logic [31:0] vals [2];
    vals  = '{32'hFFFF_FF80, 32'hFFFF_FFFF};
    done0 = done_cnt;
    exp_q.push_back(32'hFFFF_FF00);
    start_sweep(MODE_ONESHOT, 32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h80, 0);
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(vals[i]);
      pulse_tick();
      checks++; if (phase_step !== vals[i]) begin errors++; $display("FAIL wrap_step%0d: got %0h expected %0h", i, phase_step, vals[i]); end
    end
    pulse_tick();
    checks++; if (phase_step !== 32'd0 || busy !== 1'b0) begin errors++; $display("FAIL wrap_end: got phase=%0h busy=%b expected 0/0", phase_step, busy); end
    checks++; if (done_cnt - done0 != 1) begin errors++; $display("FAIL wrap_done: got %0d pulses expected 1", done_cnt - done0); end
  endtask

  task automatic test_hold();
    int upd0;
    upd0 = upd_cnt;
    exp_q.push_back(32'd50);
    start_sweep(MODE_ONESHOT, 50, 100, 0, 1);
    for (int i = 0; i < 4; i++) pulse_tick();
    checks++; if (phase_step !== 32'd50 || busy !== 1'b1) begin errors++; $display("FAIL inc0_hold: got phase=%0d busy=%b expected 50/1", phase_step, busy); end
    checks++; if (upd_cnt - upd0 != 1) begin errors++; $display("FAIL inc0_upd: got %0d expected 1", upd_cnt - upd0); end
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    upd0 = upd_cnt;
    exp_q.push_back(32'd77);
    start_sweep(MODE_PINGPONG, 77, 77, 5, 1);
    for (int i = 0; i < 4; i++) pulse_tick();
    checks++; if (phase_step !== 32'd77 || busy !== 1'b1) begin errors++; $display("FAIL eq_hold: got phase=%0d busy=%b expected 77/1", phase_step, busy); end
    checks++; if (upd_cnt - upd0 != 1) begin errors++; $display("FAIL eq_upd: got %0d expected 1", upd_cnt - upd0); end
    abort = 1'b1;
    cyc();
    abort = 1'b0;
  endtask

  task automatic test_errors();
    int          err0;
    logic [31:0] vals [3];
    vals = '{32'd20, 32'd30, 32'd10};
    err0 = err_cnt;
    start_sweep(MODE_ONESHOT, 500, 100, 1, 1);
    checks++; if (cfg_err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL err_range: got cfg_err=%b busy=%b expected 1/0", cfg_err, busy); end
    cyc();
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL err_pulse_width: got %b expected 0", cfg_err); end
    start_sweep(MODE_RSVD, 10, 20, 1, 1);
    checks++; if (cfg_err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL err_mode3: got cfg_err=%b busy=%b expected 1/0", cfg_err, busy); end
    cyc();
    checks++; if (err_cnt - err0 != 2) begin errors++; $display("FAIL err_count: got %0d expected 2", err_cnt - err0); end
    exp_q.push_back(32'd10);
    start_sweep(MODE_LOOP, 10, 30, 10, 1);
    start_sweep(MODE_ONESHOT, 1000, 2000, 500, 5);
    checks++; if (phase_step !== 32'd10 || cfg_err !== 1'b0) begin errors++; $display("FAIL busy_start: got phase=%0d cfg_err=%b expected 10/0", phase_step, cfg_err); end
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(vals[i]);
      pulse_tick();
      checks++; if (phase_step !== vals[i]) begin errors++; $display("FAIL shadow_step%0d: got %0d expected %0d", i, phase_step, vals[i]); end
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (phase_step !== 32'd0 || busy !== 1'b0) begin errors++; $display("FAIL async_reset: got phase=%0d busy=%b expected 0/0", phase_step, busy); end
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) pulse_tick();
    checks++; if (phase_step !== 32'd0 || busy !== 1'b0) begin errors++; $display("FAIL no_resume: got phase=%0d busy=%b expected 0/0", phase_step, busy); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL err_pending: got %0d expected 0", exp_q.size()); end
  endtask

  initial begin
    fork
      sb_monitor();
    join_none
    test_reset();
    test_oneshot();
    test_clamp();
    test_loop();
    test_pingpong();
    test_wrap();
    test_hold();
    test_errors();
    cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
